// File: rtl/smp_pkg.sv
// Shared opcode, one-hot bit and FSM state definitions for the SMP instruction front end.
package smp_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDAC = 4'h1;
   localparam logic [3:0] OP_STAC = 4'h2;
   localparam logic [3:0] OP_MVAC = 4'h3;
   localparam logic [3:0] OP_MOVR = 4'h4;
   localparam logic [3:0] OP_JUMP = 4'h5;
   localparam logic [3:0] OP_JMPZ = 4'h6;
   localparam logic [3:0] OP_JPNZ = 4'h7;
   localparam logic [3:0] OP_ADD  = 4'h8;
   localparam logic [3:0] OP_SUB  = 4'h9;
   localparam logic [3:0] OP_INAC = 4'hA;
   localparam logic [3:0] OP_CLAC = 4'hB;
   localparam logic [3:0] OP_AND  = 4'hC;
   localparam logic [3:0] OP_OR   = 4'hD;
   localparam logic [3:0] OP_XOR  = 4'hE;
   localparam logic [3:0] OP_NOT  = 4'hF;

   // Opcode index n lands on one-hot bit 15-n.
   localparam int unsigned B_NOP  = 15;
   localparam int unsigned B_LDAC = 14;
   localparam int unsigned B_STAC = 13;
   localparam int unsigned B_MVAC = 12;
   localparam int unsigned B_MOVR = 11;
   localparam int unsigned B_JUMP = 10;
   localparam int unsigned B_JMPZ = 9;
   localparam int unsigned B_JPNZ = 8;
   localparam int unsigned B_ADD  = 7;
   localparam int unsigned B_SUB  = 6;
   localparam int unsigned B_INAC = 5;
   localparam int unsigned B_CLAC = 4;
   localparam int unsigned B_AND  = 3;
   localparam int unsigned B_OR   = 2;
   localparam int unsigned B_XOR  = 1;
   localparam int unsigned B_NOT  = 0;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      OPND  = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } state_t;

endpackage

// File: rtl/opcode_onehot.sv
// Combinational opcode byte decoder: validity, operand requirement and one-hot instruction.
module opcode_onehot
   import smp_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              needs_operand,
   output logic [15:0]       onehot
);

   always_comb begin
      valid         = (data[DATA_W-1:4] == '0);
      needs_operand = 1'b0;
      onehot        = '0;
      case (data[3:0])
         OP_NOP:  onehot[B_NOP]  = 1'b1;
         OP_LDAC: begin onehot[B_LDAC] = 1'b1; needs_operand = 1'b1; end
         OP_STAC: begin onehot[B_STAC] = 1'b1; needs_operand = 1'b1; end
         OP_MVAC: onehot[B_MVAC] = 1'b1;
         OP_MOVR: onehot[B_MOVR] = 1'b1;
         OP_JUMP: begin onehot[B_JUMP] = 1'b1; needs_operand = 1'b1; end
         OP_JMPZ: begin onehot[B_JMPZ] = 1'b1; needs_operand = 1'b1; end
         OP_JPNZ: begin onehot[B_JPNZ] = 1'b1; needs_operand = 1'b1; end
         OP_ADD:  onehot[B_ADD]  = 1'b1;
         OP_SUB:  onehot[B_SUB]  = 1'b1;
         OP_INAC: onehot[B_INAC] = 1'b1;
         OP_CLAC: onehot[B_CLAC] = 1'b1;
         OP_AND:  onehot[B_AND]  = 1'b1;
         OP_OR:   onehot[B_OR]   = 1'b1;
         OP_XOR:  onehot[B_XOR]  = 1'b1;
         OP_NOT:  onehot[B_NOT]  = 1'b1;
         default: onehot = '0;
      endcase
      if (!valid) begin
         onehot        = '0;
         needs_operand = 1'b0;
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Sequenced fetch/operand/issue front end owning the PC and jump resolution.
// Optional macro HALT_ON_ILLEGAL_EN: an illegal opcode parks the FSM in HALT until reset.
module instr_sequencer
   import smp_pkg::*;
#(
   parameter int unsigned       DATA_W = 8,
   parameter int unsigned       ADDR_W = 16,
   parameter logic [ADDR_W-1:0] PC_RST = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   input  logic              z_flag,
   output logic [15:0]       ins_onehot,
   output logic              ins_valid,
   input  logic              ins_ready,
   output logic [ADDR_W-1:0] operand,
   output logic [ADDR_W-1:0] pc,
   output logic              illegal
);

   localparam int unsigned      NB       = ADDR_W / DATA_W;
   localparam int unsigned      CNT_W    = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] operand_q, operand_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [15:0]       onehot_q, onehot_d;
   logic              illegal_q, illegal_d;
   logic              rst_q;
   logic              req, ack, take_jump;
   logic              dec_valid, dec_needs_opnd;
   logic [15:0]       dec_onehot;

   opcode_onehot #(.DATA_W(DATA_W)) u_dec (
      .data          (mem_rdata),
      .valid         (dec_valid),
      .needs_operand (dec_needs_opnd),
      .onehot        (dec_onehot)
   );

   // rst_q holds mem_req low for the cycle following any reset edge.
   assign req       = ((state_q == FETCH) || (state_q == OPND)) && !rst_q;
   assign ack       = req && mem_ack;
   assign take_jump = onehot_q[B_JUMP] || (onehot_q[B_JMPZ] && z_flag) ||
                      (onehot_q[B_JPNZ] && !z_flag);

   assign mem_req    = req;
   assign mem_addr   = pc_q;
   assign ins_valid  = (state_q == ISSUE);
   assign ins_onehot = ins_valid ? onehot_q : '0;
   assign operand    = operand_q;
   assign pc         = pc_q;
   assign illegal    = illegal_q;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      operand_d = operand_q;
      cnt_d     = cnt_q;
      onehot_d  = onehot_q;
      illegal_d = 1'b0;
      case (state_q)
         FETCH: begin
            if (ack) begin
               pc_d      = pc_q + ADDR_W'(1);
               operand_d = '0;
               if (!dec_valid) begin
                  illegal_d = 1'b1;
`ifdef HALT_ON_ILLEGAL_EN
                  state_d   = HALT;
`else
                  state_d   = FETCH;
`endif
               end else begin
                  onehot_d = dec_onehot;
                  state_d  = dec_needs_opnd ? OPND : ISSUE;
               end
            end
         end
         OPND: begin
            if (ack) begin
               operand_d[int'(cnt_q)*DATA_W +: DATA_W] = mem_rdata;
               pc_d = pc_q + ADDR_W'(1);
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ISSUE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ISSUE: begin
            if (ins_ready) begin
               state_d = FETCH;
               if (take_jump) pc_d = operand_q;
            end
         end
         HALT: state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH;
         pc_q      <= PC_RST;
         operand_q <= '0;
         cnt_q     <= '0;
         onehot_q  <= '0;
         illegal_q <= 1'b0;
         rst_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         operand_q <= operand_d;
         cnt_q     <= cnt_d;
         onehot_q  <= onehot_d;
         illegal_q <= illegal_d;
         rst_q     <= 1'b0;
      end
   end

endmodule
